// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with imem/dmem handshakes and sticky halt/fault.
// Optional feature: define SEQ_PERF_CNT_EN to add the retired_cnt instruction counter output.
module core_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr_in,
  output logic [31:0] ir,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        req_halt,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        pc_en,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_ir;
  logic             r_imem_req;
  logic             r_dmem_req;
  logic             r_dmem_we;
  logic             r_rf_we;
  logic             r_halted;
  logic             r_fault;
  logic             w_timeout;

  // r_cnt holds the number of unacked request cycles already spent in this state.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)       w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: w_next = req_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (mem_read || mem_write) w_next = S_MEM;
        else if (reg_write)        w_next = S_WB;
        else                       w_next = S_FETCH;
      end
      S_MEM: begin
        if (dmem_ack)       w_next = (mem_read && reg_write) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
  end

  // PC strobe is the only Mealy output: it must coincide with the dmem ack cycle.
  always_comb begin
    pc_en = 1'b0;
    case (r_state)
      S_EXEC:  pc_en = !(mem_read || mem_write) && !reg_write;
      S_MEM:   pc_en = dmem_ack && !(mem_read && reg_write);
      S_WB:    pc_en = 1'b1;
      default: pc_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ir       <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_imem_req <= (w_next == S_FETCH);
      r_dmem_req <= (w_next == S_MEM);
      r_dmem_we  <= (w_next == S_MEM) && ((r_state == S_MEM) ? r_dmem_we : mem_write);
      r_rf_we    <= (w_next == S_WB);
      r_halted   <= (w_next == S_HALT);
      r_fault    <= (w_next == S_FAULT);
      if ((r_state == S_FETCH) && imem_ack)
        r_ir <= instr_in;
      // Any state change clears the wait counter, so every FETCH/MEM entry starts at zero.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (((r_state == S_FETCH) || (r_state == S_MEM)) && (MEM_TIMEOUT != 0))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign imem_req = r_imem_req;
  assign dmem_req = r_dmem_req;
  assign dmem_we  = r_dmem_we;
  assign rf_we    = r_rf_we;
  assign halted   = r_halted;
  assign fault    = r_fault;
  assign ir       = r_ir;
  assign state    = r_state;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_retired;

  // No pc_en is ever issued in HALT/FAULT, so the count freezes there by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_retired <= '0;
    else if (pc_en) r_retired <= r_retired + 32'd1;
  end

  assign retired_cnt = r_retired;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-instruction trace model, random episodes, directed cases.
module tb_core_sequencer;
  localparam int T = 16;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic [31:0] ir;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        req_halt;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        pc_en;
  logic        halted;
  logic        fault;
  logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] mcnt;
  logic [31:0] cq[$];
`endif

  core_sequencer #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr_in(instr_in), .ir(ir),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .req_halt(req_halt),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_en(pc_en), .halted(halted), .fault(fault), .state(state)
`ifdef SEQ_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output image of one clock cycle.
  typedef struct packed {
    logic [2:0]  st;
    logic        ireq, dreq, dwe, rfwe, pce, hlt, flt;
    logic [31:0] ir;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  lg[$];
  logic [31:0] mir;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: one check per cycle that has an expectation queued.
  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cycle", 64'({state, imem_req, dmem_req, dmem_we, rf_we, pc_en, halted, fault, ir}), 64'(e));
        lg.push_back({state, imem_req, dmem_req, dmem_we, rf_we, pc_en});
`ifdef SEQ_PERF_CNT_EN
        chk("retired_cnt", 64'(retired_cnt), 64'(cq.pop_front()));
`endif
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic garb;
    imem_ack  = 1'($urandom);
    dmem_ack  = 1'($urandom);
    instr_in  = $urandom;
    mem_read  = 1'($urandom);
    mem_write = 1'($urandom);
    reg_write = 1'($urandom);
    req_halt  = 1'($urandom);
  endtask

  task automatic flags(input bit mr, input bit mw, input bit rw);
    mem_read  = mr;
    mem_write = mw;
    reg_write = rw;
  endtask

  task automatic push(input logic [2:0] st, input logic ireq, input logic dreq, input logic dwe,
                      input logic rfwe, input logic pce, input logic hlt, input logic flt);
    exp_t e;
    e = {st, ireq, dreq, dwe, rfwe, pce, hlt, flt, mir};
    q.push_back(e);
`ifdef SEQ_PERF_CNT_EN
    cq.push_back(mcnt);
    mcnt += 32'(pce);
`endif
  endtask

  task automatic absorb(input logic [2:0] st);
    for (int i = 0; i < 20; i++) begin
      tick; garb;
      push(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st == 3'd6, st == 3'd7);
    end
  endtask

  // One instruction: fetch ack in req cycle lf (0 = never), data ack in req cycle lm (0 = never).
  task automatic run_instr(input int lf, input bit mr, input bit mw, input bit rw, input bit hl,
                           input int lm, input logic [31:0] iw, output bit done);
    int nf;
    int nm;
    done = 1'b0;
    nf = (lf == 0) ? T : lf;
    for (int c = 1; c <= nf; c++) begin
      tick; garb;
      imem_ack = (c == lf);
      if (c == lf) instr_in = iw;
      push(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (lf == 0) begin
      absorb(3'd7);
      done = 1'b1;
      return;
    end
    mir = iw;
    tick; garb; flags(mr, mw, rw);
    req_halt = hl;
    push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (hl) begin
      absorb(3'd6);
      done = 1'b1;
      return;
    end
    tick; garb; flags(mr, mw, rw);
    push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, !(mr || mw) && !rw, 1'b0, 1'b0);
    if (mr || mw) begin
      nm = (lm == 0) ? T : lm;
      for (int c = 1; c <= nm; c++) begin
        tick; garb; flags(mr, mw, rw);
        dmem_ack = (c == lm);
        push(3'd4, 1'b0, 1'b1, mw, 1'b0, (c == lm) && !(mr && rw), 1'b0, 1'b0);
      end
      if (lm == 0) begin
        absorb(3'd7);
        done = 1'b1;
        return;
      end
    end
    if ((mr || mw) ? (mr && rw) : rw) begin
      tick; garb;
      push(3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic zero_inputs;
    imem_ack = 0; dmem_ack = 0; instr_in = '0;
    mem_read = 0; mem_write = 0; reg_write = 0; req_halt = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    zero_inputs;
    #1;
    chk("reset_outputs", 64'({state, imem_req, dmem_req, dmem_we, rf_we, pc_en, halted, fault, ir}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", 64'(state), 64'd0);
    mir = '0;
`ifdef SEQ_PERF_CNT_EN
    mcnt = '0;
`endif
    lg.delete();
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [7:0] exp);
    logic [7:0] v;
    v = (idx < lg.size()) ? lg[idx] : 8'hFF;
    chk(nm, 64'(v), 64'(exp));
  endtask

  function automatic int cnt_log(input logic [7:0] v);
    int n;
    n = 0;
    foreach (lg[i]) if (lg[i] == v) n++;
    return n;
  endfunction

  int lf, lm, r;
  bit mr, mw, rw, hl, done;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    mir = '0;
`ifdef SEQ_PERF_CNT_EN
    mcnt = '0;
`endif
    zero_inputs;

    // ADD, zero-wait fetch: FETCH, DECODE, EXEC, WB
    do_reset;
    run_instr(1, 0, 0, 1, 0, 0, 32'hE081_1002, done);
    settle;
    chk("t1_len", 64'(lg.size()), 64'd4);
    chk_log("t1_fetch", 0, 8'h30);
    chk_log("t1_decode", 1, 8'h40);
    chk_log("t1_exec", 2, 8'h60);
    chk_log("t1_wb", 3, 8'hA3);
    chk("t1_ir", 64'(ir), 64'hE081_1002);

    // LDR with three data request cycles
    do_reset;
    run_instr(1, 1, 0, 1, 0, 3, 32'hF840_0041, done);
    settle;
    chk("t2_len", 64'(lg.size()), 64'd7);
    chk("t2_mem_cycles", 64'(cnt_log(8'h88)), 64'd3);
    chk_log("t2_wb", 6, 8'hA3);

    // STR with both mem flags: store wins, pc_en on ack, no writeback
    do_reset;
    run_instr(1, 1, 1, 0, 0, 1, 32'hF800_0041, done);
    settle;
    chk("t3_len", 64'(lg.size()), 64'd4);
    chk_log("t3_mem_ack", 3, 8'h8D);

    // HLT: absorbing halt
    do_reset;
    run_instr(1, 0, 0, 0, 1, 0, 32'hD440_0000, done);
    settle;
    chk_log("t4_decode", 1, 8'h40);
    chk("t4_halt_cycles", 64'(cnt_log(8'hC0)), 64'd20);
    chk("t4_halted", 64'(halted), 64'd1);

    // fetch timeout, then ack in the last permitted cycle
    do_reset;
    run_instr(0, 0, 0, 0, 0, 0, 32'h0, done);
    settle;
    chk("t5_req_cycles", 64'(cnt_log(8'h30)), 64'd16);
    chk_log("t5_fault_entry", 16, 8'hE0);
    chk("t5_fault", 64'(fault), 64'd1);
    do_reset;
    run_instr(T, 0, 0, 0, 0, 0, 32'h1400_0001, done);
    settle;
    chk_log("t5b_last_req", 15, 8'h30);
    chk_log("t5b_decode", 16, 8'h40);
    chk_log("t5b_exec_pc", 17, 8'h61);

    // asynchronous reset in the middle of MEM
    do_reset;
    tick; imem_ack = 1'b1; instr_in = 32'hF840_0041;
    tick; imem_ack = 1'b0; flags(1, 0, 1);
    tick;
    tick; dmem_ack = 1'b0;
    chk("t6_in_mem", 64'({state, dmem_req, ir}), 64'({3'd4, 1'b1, 32'hF840_0041}));
    #2 rst_n = 1'b0;
    #1 chk("t6_async_clear", 64'({state, dmem_req, ir}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    zero_inputs;
    #1 chk("t6_idle", 64'(state), 64'd0);
    tick;
    chk("t6_fetch", 64'({state, imem_req}), 64'({3'd1, 1'b1}));

    // randomized episodes
    for (int ep = 0; ep < 25; ep++) begin
      do_reset;
      for (int k = 0; k < 12; k++) begin
        r  = $urandom_range(0, 39);
        lf = (r == 0) ? 0 : (r < 30) ? $urandom_range(1, 3) : $urandom_range(4, T);
        r  = $urandom_range(0, 39);
        lm = (r == 0) ? 0 : (r < 30) ? $urandom_range(1, 3) : $urandom_range(4, T);
        mr = 1'($urandom);
        mw = 1'($urandom);
        rw = 1'($urandom);
        hl = ($urandom_range(0, 29) == 0);
        run_instr(lf, mr, mw, rw, hl, lm, $urandom, done);
        if (done) break;
      end
      settle;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
